// File: rtl/vending_mealy.sv
// Mealy vending FSM: price 20, coins 5/10, one 5-unit change; optional sales counter under VENDING_SALES_CNT_EN.
// Latency: dispense/chg5 are combinational from state_reg and coin (same cycle); state updates at the next edge.
// Backpressure: none, a coin code is consumed on every rising edge.
module vending_mealy (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin,
    output logic       dispense,
    output logic       chg5
`ifdef VENDING_SALES_CNT_EN
    ,
    output logic [7:0] sales_cnt
`endif
);

    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10,
        S15 = 2'b11
    } state_t;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    state_t state_reg;
    state_t state_nxt;

    // Idle and invalid codes fall through the defaults: hold state, no outputs.
    always_comb begin
        state_nxt = state_reg;
        dispense  = 1'b0;
        chg5      = 1'b0;
        unique case (state_reg)
            S0: begin
                if (coin == COIN_5)  state_nxt = S5;
                if (coin == COIN_10) state_nxt = S10;
            end
            S5: begin
                if (coin == COIN_5)  state_nxt = S10;
                if (coin == COIN_10) state_nxt = S15;
            end
            S10: begin
                if (coin == COIN_5)  state_nxt = S15;
                if (coin == COIN_10) begin
                    state_nxt = S0;
                    dispense  = 1'b1;
                end
            end
            S15: begin
                if (coin == COIN_5) begin
                    state_nxt = S0;
                    dispense  = 1'b1;
                end
                if (coin == COIN_10) begin
                    state_nxt = S0;
                    dispense  = 1'b1;
                    chg5      = 1'b1;
                end
            end
            default: state_nxt = S0;
        endcase
        // Keep outputs quiet throughout reset even before state_reg settles.
        if (!rst) begin
            dispense = 1'b0;
            chg5     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S0;
        else      state_reg <= state_nxt;
    end

`ifdef VENDING_SALES_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          sales_cnt <= 8'd0;
        else if (dispense) sales_cnt <= sales_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vending_mealy.sv
// Randomized + directed bench for vending_mealy against a credit-arithmetic reference model.
module tb_vending_mealy;

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic       dispense;
    logic       chg5;
`ifdef VENDING_SALES_CNT_EN
    logic [7:0] sales_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: credit in units, sales count modulo 256.
    int credit  = 0;
    int sales_m = 0;

    vending_mealy dut (
        .clk      (clk),
        .rst      (rst),
        .coin     (coin),
        .dispense (dispense),
        .chg5     (chg5)
`ifdef VENDING_SALES_CNT_EN
        ,
        .sales_cnt(sales_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coin_val(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            default: return 0;
        endcase
    endfunction

    // Present one coin for one cycle, check the Mealy outputs, then advance the model past the edge.
    task automatic apply(input logic [1:0] c, input string tag);
        int total;
        @(negedge clk);
        coin = c;
        #1;
        total = credit + coin_val(c);
        check({tag, ".state"},    int'(dut.state_reg), credit / 5);
        check({tag, ".dispense"}, int'(dispense),      (total >= 20) ? 1 : 0);
        check({tag, ".chg5"},     int'(chg5),          (total == 25) ? 1 : 0);
`ifdef VENDING_SALES_CNT_EN
        check({tag, ".sales"},    int'(sales_cnt),     sales_m);
`endif
        if (total >= 20) begin
            credit  = 0;
            sales_m = (sales_m + 1) % 256;
        end else begin
            credit = total;
        end
    endtask

    // Assert reset mid-cycle, verify async clear, hold across an edge, release.
    task automatic pulse_reset(input string tag);
        #1;
        rst = 1'b0;
        #1;
        credit  = 0;
        sales_m = 0;
        check({tag, ".rst_state"}, int'(dut.state_reg), 0);
        check({tag, ".rst_disp"},  int'(dispense),      0);
        check({tag, ".rst_chg5"},  int'(chg5),          0);
        @(posedge clk);
        #1;
        coin = 2'b10;
        #1;
        check({tag, ".hold_state"}, int'(dut.state_reg), 0);
        check({tag, ".hold_disp"},  int'(dispense),      0);
`ifdef VENDING_SALES_CNT_EN
        check({tag, ".rst_sales"},  int'(sales_cnt),     0);
`endif
        @(negedge clk);
        coin = 2'b00;
        rst  = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        coin = 2'b11;
        #3;
        check("por.state", int'(dut.state_reg), 0);
        check("por.disp",  int'(dispense),      0);
        check("por.chg5",  int'(chg5),          0);
        @(negedge clk);
        rst = 1'b1;

        // 10,10: vend without change
        apply(2'b10, "d1.c0"); apply(2'b10, "d1.c1"); apply(2'b00, "d1.after");
        // 5,5,5,5
        apply(2'b01, "d2.c0"); apply(2'b01, "d2.c1"); apply(2'b01, "d2.c2");
        apply(2'b01, "d2.c3"); apply(2'b00, "d2.after");
        // 10,5,10: vend with change
        apply(2'b10, "d3.c0"); apply(2'b01, "d3.c1"); apply(2'b10, "d3.c2");
        apply(2'b00, "d3.after");
        // 5,idle,10,invalid,5
        apply(2'b01, "d4.c0"); apply(2'b00, "d4.c1"); apply(2'b10, "d4.c2");
        apply(2'b11, "d4.c3"); apply(2'b01, "d4.c4"); apply(2'b00, "d4.after");

        // Reset while in S15 with a 10 presented
        apply(2'b10, "d5.c0"); apply(2'b01, "d5.c1");
        @(negedge clk);
        coin = 2'b10;
        #1;
        check("d5.pre_disp", int'(dispense), 1);
        check("d5.pre_chg5", int'(chg5),     1);
        pulse_reset("d5");
        apply(2'b01, "d5.post0"); apply(2'b00, "d5.post1");

`ifdef VENDING_SALES_CNT_EN
        pulse_reset("sc");
        for (int i = 0; i < 3; i++) begin
            apply(2'b10, "sc.a"); apply(2'b10, "sc.b");
        end
        @(negedge clk);
        coin = 2'b00;
        #1;
        check("sc.three", int'(sales_cnt), 3);
        for (int i = 3; i < 256; i++) begin
            apply(2'b10, "sc.a"); apply(2'b10, "sc.b");
        end
        @(negedge clk);
        coin = 2'b00;
        #1;
        check("sc.wrap", int'(sales_cnt), 0);
`endif

        // Random coins with occasional mid-transaction resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                @(negedge clk);
                coin = 2'($urandom_range(0, 3));
                pulse_reset("rnd");
            end else begin
                apply(2'($urandom_range(0, 3)), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
